// File: rtl/bistprj_mbist_ctrl.sv
// March C- BIST engine driving one single-port SRAM and reporting first-failure diagnostics.
// Latency: first access is on the bus one cycle after the START edge; run takes 10N+1 cycles.
// Backpressure: none; the SRAM accepts one access per cycle, and ABORT stops the run on the next edge.
module bistprj_mbist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              MAS_CLK,
  input  logic              MAS_RST,
  input  logic              BIST_START,
  input  logic              BIST_ABORT,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_CE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              BIST_BUSY,
  output logic              BIST_DONE,
  output logic              BIST_FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [2:0]        FAIL_ELEM,
  output logic [CNT_W-1:0]  FAIL_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_CMP_LAST = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] BG0       = '0;
  localparam logic [DATA_W-1:0] BG1       = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  // Elements 0..2 walk addresses upward, 3..5 downward.
  function automatic logic elem_up(input logic [2:0] e);
    return (e <= 3'd2);
  endfunction

  // Every element except M0 starts each address with a read.
  function automatic logic elem_has_rd(input logic [2:0] e);
    return (e != 3'd0);
  endfunction

  // Every element except M5 ends each address with a write.
  function automatic logic elem_has_wr(input logic [2:0] e);
    return (e != ELEM_LAST);
  endfunction

  // Background expected by the read of an element: r1 in M2/M4, r0 elsewhere.
  function automatic logic [DATA_W-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? BG1 : BG0;
  endfunction

  // Background written by an element: w1 in M1/M3, w0 elsewhere.
  function automatic logic [DATA_W-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? BG1 : BG0;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ce_d, we_d;
  logic [DATA_W-1:0] wdata_d;
  logic              start_q;
  logic              start_edge;
  logic              last_addr;
  logic              run_go;
  logic              done_set;
  logic              rd_issue;
  logic              cmp_hit;

  // Read pipeline: expected data, element and address travel with each read
  // so the compare in the following cycle knows what it is checking.
  logic              pend_q;
  logic [DATA_W-1:0] pend_exp_q;
  logic [2:0]        pend_elem_q;
  logic [ADDR_W-1:0] pend_addr_q;

  assign start_edge = BIST_START & ~start_q;
  assign last_addr  = elem_up(elem_q) ? (MEM_ADDR == ADDR_MAX) : (MEM_ADDR == ADDR_ZERO);
  assign rd_issue   = (state_q == ST_RUN) && MEM_CE && !MEM_WE;
  assign cmp_hit    = pend_q && !BIST_ABORT && (MEM_RDATA != pend_exp_q);

  // Next-state and next-access decode: walks element/address/phase one op per cycle.
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = MEM_ADDR;
    ce_d     = MEM_CE;
    we_d     = MEM_WE;
    wdata_d  = MEM_WDATA;
    run_go   = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ce_d = 1'b0;
        we_d = 1'b0;
        // ABORT wins over a coincident START edge.
        if (start_edge && !BIST_ABORT) begin
          run_go  = 1'b1;
          state_d = ST_RUN;
          elem_d  = 3'd0;
          addr_d  = ADDR_ZERO;
          ce_d    = 1'b1;
          we_d    = 1'b1;
          wdata_d = wr_bg(3'd0);
        end
      end
      ST_RUN: begin
        if (BIST_ABORT) begin
          state_d = ST_IDLE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
        end else if (elem_has_rd(elem_q) && elem_has_wr(elem_q) && !MEM_WE) begin
          // Read just issued: the write to the same address follows immediately.
          we_d    = 1'b1;
          wdata_d = wr_bg(elem_q);
        end else if (!last_addr) begin
          addr_d  = elem_up(elem_q) ? (MEM_ADDR + ADDR_ONE) : (MEM_ADDR - ADDR_ONE);
          we_d    = !elem_has_rd(elem_q);
          wdata_d = wr_bg(elem_q);
        end else if (elem_q == ELEM_LAST) begin
          // Final read of M5 is on the bus; its data still has to be compared.
          state_d = ST_CMP_LAST;
          ce_d    = 1'b0;
          we_d    = 1'b0;
        end else begin
          // Element boundary: reload the counter, no bubble. M1..M5 all open with a read.
          elem_d  = elem_q + 3'd1;
          addr_d  = elem_up(elem_q + 3'd1) ? ADDR_ZERO : ADDR_MAX;
          we_d    = 1'b0;
          wdata_d = wr_bg(elem_q + 3'd1);
        end
      end
      ST_CMP_LAST: begin
        ce_d     = 1'b0;
        we_d     = 1'b0;
        state_d  = ST_IDLE;
        done_set = !BIST_ABORT;
      end
      default: begin
        state_d = ST_IDLE;
        ce_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // FSM state and the registered SRAM access bus.
  always_ff @(posedge MAS_CLK or negedge MAS_RST) begin
    if (!MAS_RST) begin
      state_q   <= ST_IDLE;
      elem_q    <= 3'd0;
      MEM_CE    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= ADDR_ZERO;
      MEM_WDATA <= BG0;
      BIST_BUSY <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      MEM_CE    <= ce_d;
      MEM_WE    <= we_d;
      MEM_ADDR  <= addr_d;
      MEM_WDATA <= wdata_d;
      BIST_BUSY <= (state_d != ST_IDLE);
    end
  end

  // START edge history and read-compare pipeline; an abort drops any in-flight read.
  always_ff @(posedge MAS_CLK or negedge MAS_RST) begin
    if (!MAS_RST) begin
      start_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_exp_q  <= BG0;
      pend_elem_q <= 3'd0;
      pend_addr_q <= ADDR_ZERO;
    end else begin
      start_q     <= BIST_START;
      pend_q      <= rd_issue && !BIST_ABORT;
      pend_exp_q  <= rd_bg(elem_q);
      pend_elem_q <= elem_q;
      pend_addr_q <= MEM_ADDR;
    end
  end

  // Sticky status and first-failure capture; cleared when a new run is accepted.
  always_ff @(posedge MAS_CLK or negedge MAS_RST) begin
    if (!MAS_RST) begin
      BIST_DONE  <= 1'b0;
      BIST_FAIL  <= 1'b0;
      FAIL_ADDR  <= ADDR_ZERO;
      FAIL_ELEM  <= 3'd0;
      FAIL_COUNT <= '0;
    end else if (run_go) begin
      BIST_DONE  <= 1'b0;
      BIST_FAIL  <= 1'b0;
      FAIL_ADDR  <= ADDR_ZERO;
      FAIL_ELEM  <= 3'd0;
      FAIL_COUNT <= '0;
    end else begin
      if (done_set) begin
        BIST_DONE <= 1'b1;
      end
      if (cmp_hit) begin
        BIST_FAIL <= 1'b1;
        if (FAIL_COUNT != CNT_MAX) begin
          FAIL_COUNT <= FAIL_COUNT + CNT_ONE;
        end
        if (!BIST_FAIL) begin
          FAIL_ADDR <= pend_addr_q;
          FAIL_ELEM <= pend_elem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bistprj_mbist_ctrl.sv
// Directed bench for the March C- engine: clean, stuck-at, abort, held START, reset and saturation runs.
// Latency: checks one-cycle start latency and the 10N+1 busy window against hand-derived numbers.
// Backpressure: none; a behavioural SRAM answers every access one cycle later.
module tb_bistprj_mbist_ctrl;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] rdata;
  logic       ce, we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_cnt;

  logic       start6;
  logic       abort6;
  logic [7:0] rdata6;
  logic       ce6, we6;
  logic [5:0] addr6;
  logic [7:0] wdata6;
  logic       busy6, done6, fail6;
  logic [5:0] fail_addr6;
  logic [2:0] fail_elem6;
  logic [7:0] fail_cnt6;

  int errs   = 0;
  int checks = 0;

  logic [7:0]  mem [N];
  bit          fault_en = 1'b0;
  logic [12:0] exp_ops [$];

  always #5 clk = ~clk;

  bistprj_mbist_ctrl #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
    .MAS_CLK(clk), .MAS_RST(rst_n), .BIST_START(start), .BIST_ABORT(abort),
    .MEM_RDATA(rdata), .MEM_CE(ce), .MEM_WE(we), .MEM_ADDR(addr), .MEM_WDATA(wdata),
    .BIST_BUSY(busy), .BIST_DONE(done), .BIST_FAIL(fail),
    .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem), .FAIL_COUNT(fail_cnt)
  );

  bistprj_mbist_ctrl #(.ADDR_W(6), .DATA_W(8), .CNT_W(8)) dut6 (
    .MAS_CLK(clk), .MAS_RST(rst_n), .BIST_START(start6), .BIST_ABORT(abort6),
    .MEM_RDATA(rdata6), .MEM_CE(ce6), .MEM_WE(we6), .MEM_ADDR(addr6), .MEM_WDATA(wdata6),
    .BIST_BUSY(busy6), .BIST_DONE(done6), .BIST_FAIL(fail6),
    .FAIL_ADDR(fail_addr6), .FAIL_ELEM(fail_elem6), .FAIL_COUNT(fail_cnt6)
  );

  assign rdata6 = 8'h5A;

  // Behavioural SRAM: read data valid the cycle after the access; optional bit-0 stuck-at-1 at address 5.
  always @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= wdata;
      else    rdata <= mem[addr] | {7'b0, (fault_en && addr == 4'd5)};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launches a run with a one-cycle START pulse (or held START) and follows it until BUSY drops.
  task automatic run_watch(input bit hold, input int abort_at, input int pulse_at,
                           output int busy_cyc, output int ce_cyc, output int op_err);
    logic [12:0] act, expv;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_clr", {19'b0, done, fail, fail_cnt, fail_addr}, 32'd0);
    busy_cyc = 0;
    ce_cyc   = 0;
    op_err   = 0;
    while (busy && busy_cyc < 400) begin
      busy_cyc++;
      if (ce) begin
        act  = {we, addr, (we ? wdata : 8'h00)};
        expv = (ce_cyc < exp_ops.size()) ? exp_ops[ce_cyc] : 13'h1FFF;
        if (act !== expv) op_err++;
        ce_cyc++;
      end
      if (busy_cyc == abort_at) abort = 1'b1;
      if (busy_cyc == pulse_at) start = 1'b0;
      if (busy_cyc == pulse_at + 1) start = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, cc, oe, act_cnt;
    logic [3:0] a4;

    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a4 = (e <= 2) ? 4'(i) : 4'(N - 1 - i);
        if (e != 0) exp_ops.push_back({1'b0, a4, 8'h00});
        if (e != 5) exp_ops.push_back({1'b1, a4, ((e == 1 || e == 3) ? 8'hFF : 8'h00)});
      end
    end
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    rdata  = 8'h00;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start6 = 1'b0;
    abort6 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {ce, we, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run
    run_watch(1'b0, 0, -10, bc, cc, oe);
    chk("clean_busy", bc, 161);
    chk("clean_ce", cc, 160);
    chk("clean_ops", oe, 0);
    chk("clean_stat", {done, fail, fail_cnt}, {1'b1, 1'b0, 8'd0});
    repeat (3) @(negedge clk);

    // Bit 0 stuck-at-1 at address 5: r0 reads in M1, M3, M5 miscompare
    fault_en = 1'b1;
    run_watch(1'b0, 0, -10, bc, cc, oe);
    chk("sa1_busy", bc, 161);
    chk("sa1_ops", oe, 0);
    chk("sa1_stat", {done, fail}, 2'b11);
    chk("sa1_addr", fail_addr, 5);
    chk("sa1_elem", fail_elem, 1);
    chk("sa1_count", fail_cnt, 3);
    repeat (3) @(negedge clk);

    // Abort at cycle 40 (fault still present: one M1 miscompare already logged)
    run_watch(1'b0, 40, -10, bc, cc, oe);
    abort = 1'b0;
    chk("abort_cyc", bc, 40);
    chk("abort_bus", {busy, ce, done}, 3'b000);
    chk("abort_diag", {fail, fail_elem, fail_addr, fail_cnt}, {1'b1, 3'd1, 4'd5, 8'd1});
    repeat (3) @(negedge clk);
    fault_en = 1'b0;
    run_watch(1'b0, 0, -10, bc, cc, oe);
    chk("rerun_busy", bc, 161);
    chk("rerun_ops", oe, 0);
    chk("rerun_stat", {done, fail, fail_addr, fail_elem, fail_cnt}, {1'b1, 1'b0, 4'd0, 3'd0, 8'd0});
    repeat (3) @(negedge clk);

    // START held high, with an extra pulse mid-run, then held 20 more cycles
    run_watch(1'b1, 0, 50, bc, cc, oe);
    chk("hold_busy", bc, 161);
    act_cnt = 0;
    repeat (20) begin
      if (busy || ce) act_cnt++;
      @(negedge clk);
    end
    chk("hold_retrig", act_cnt, 0);
    chk("hold_done", done, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort coincident with a START edge in IDLE: no run
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_vs_start", {busy, ce}, 2'b00);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset at cycle 100 of a run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {ce, we, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    act_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || ce) act_cnt++;
    end
    chk("post_rst_idle", act_cnt, 0);
    run_watch(1'b0, 0, -10, bc, cc, oe);
    chk("post_rst_run", {bc[15:0], 7'b0, done, fail, fail_cnt}, {16'd161, 7'b0, 1'b1, 1'b0, 8'd0});
    repeat (3) @(negedge clk);

    // ADDR_W=6 instance with read data stuck at 0x5A: every read fails, counter saturates
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    bc = 0;
    while (busy6 && bc < 1000) begin
      bc++;
      @(negedge clk);
    end
    chk("sat_busy", bc, 641);
    chk("sat_stat", {done6, fail6}, 2'b11);
    chk("sat_addr", fail_addr6, 0);
    chk("sat_elem", fail_elem6, 1);
    chk("sat_count", fail_cnt6, 255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bistprj_mbist_ctrl.md
# bistprj_mbist_ctrl

March C- memory BIST engine for one synchronous single-port SRAM. It sits downstream of the JTAG TDR stack in the BIST gasket: it takes start/abort controls decoded from TDR bits, drives the SRAM phy port, and returns pass/fail status and first-failure diagnostics to TDR capture registers. One instance is used per tested memory.

## Interface
- ADDR_W, 4: memory address width; N = 2^ADDR_W words tested.
- DATA_W, 8: memory data width.
- CNT_W, 8: failure counter width.

- MAS_CLK  in  1  system clock; all logic on its rising edge.
- MAS_RST  in  1  reset, asynchronous, active-low.
- BIST_START  in  1  level from TDR; a run starts on a sampled 0->1 transition.
- BIST_ABORT  in  1  level from TDR; when sampled high, the run stops.
- MEM_RDATA  in  DATA_W  SRAM read data, valid the cycle after a read access.
- MEM_CE  out  1  SRAM access enable.
- MEM_WE  out  1  1 = write, 0 = read; meaningful only when MEM_CE=1.
- MEM_ADDR  out  ADDR_W  SRAM address.
- MEM_WDATA  out  DATA_W  SRAM write data.
- BIST_BUSY  out  1  run in progress.
- BIST_DONE  out  1  sticky: last run completed (not aborted).
- BIST_FAIL  out  1  sticky: at least one miscompare in last run.
- FAIL_ADDR  out  ADDR_W  address of first miscompare.
- FAIL_ELEM  out  3  march element (1..5) of first miscompare.
- FAIL_COUNT  out  CNT_W  miscompare count, saturating at 2^CNT_W-1.

## Operation
- FSM states: IDLE, RUN, CMP_LAST. Register: element index E (0..5), address counter, op phase (R/W).
- March C- elements, with B0 = all zeros and B1 = all ones:
  - M0: up, w0.
  - M1: up, r0 w1.
  - M2: up, r1 w0.
  - M3: down, r0 w1.
  - M4: down, r1 w0.
  - M5: down, r0.
- "up" runs address 0 -> N-1; "down" runs N-1 -> 0.
- Each op takes one cycle. In r/w elements, the read cycle is immediately followed by the write cycle to the same address.
- IDLE -> RUN: on a START rising edge. Edge is detected from a registered copy of BIST_START. On that edge, BIST_DONE, BIST_FAIL, FAIL_ADDR, FAIL_ELEM and FAIL_COUNT clear.
- RUN: issues ops in sequence.
  - After the last read of M5 (address 0), go to CMP_LAST.
- CMP_LAST: no access; compares the final read, then goes to IDLE and sets BIST_DONE.
- Compare rule:
  - MEM_RDATA is compared to the expected background one cycle after each read.
  - Expected value and element are pipelined with the read.
- On a miscompare:
  - FAIL_COUNT increments (holds at max).
  - BIST_FAIL sets.
  - FAIL_ADDR and FAIL_ELEM load only if BIST_FAIL was 0 before this miscompare.
- Abort:
  - BIST_ABORT sampled high in RUN or CMP_LAST -> IDLE next cycle.
  - MEM_CE=0 from that cycle on; BIST_DONE stays 0.
  - Fail diagnostics collected so far are kept, except that the pending compare of an in-flight read is discarded.
- BIST_START edges seen while BUSY are ignored. Holding START high does not retrigger a run.
- ABORT has priority over a simultaneous START edge in IDLE: no run starts.

## Timing
- Reset values: MEM_CE=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BIST_BUSY=0, BIST_DONE=0, BIST_FAIL=0, FAIL_ADDR=0, FAIL_ELEM=0, FAIL_COUNT=0. FSM returns to IDLE.
- Reset mid-run: all outputs go to reset values immediately (asynchronous); the run is lost.
- All outputs are registered.
- Start latency:
  - Edge k: START is first sampled high after a low sample.
  - After edge k: BIST_BUSY=1 and the first access (M0 w0 at address 0) is on the bus.
- Run length:
  - M0 = N cycles, M1..M4 = 2N cycles each, M5 = N cycles, plus 1 CMP_LAST cycle.
  - BIST_BUSY is high for exactly 10N+1 cycles.
- End of run: BIST_BUSY falls and BIST_DONE rises on the same edge.
- MEM_CE stays high for 10N consecutive cycles; there are no bubbles between elements.
- Address wrap: the counter never wraps within an element. Element transitions reload the counter to 0 (up) or N-1 (down).
- Failure timing: FAIL_* updates on the edge ending the compare cycle, one cycle after the read cycle.

## Test plan
- Fault-free SRAM model, ADDR_W=4, DATA_W=8, START pulse -> BUSY high 161 cycles, then DONE=1, FAIL=0, FAIL_COUNT=0. Exactly 160 MEM_CE cycles in the order M0..M5.
- Bit 0 stuck-at-1 at address 5 -> FAIL=1, FAIL_ADDR=5, FAIL_ELEM=1, FAIL_COUNT=3 (r0 reads in M1, M3, M5), DONE=1.
- MEM_RDATA tied to 0x5A, ADDR_W=6 -> FAIL_ADDR=0, FAIL_ELEM=1, FAIL_COUNT saturates at 255, DONE=1 after 641 BUSY cycles.
- ABORT asserted at cycle 40 of the run -> next cycle BUSY=0, MEM_CE=0, DONE=0. A new START edge then runs a full 161-cycle test with diagnostics cleared.
- START held high across the whole run plus 20 cycles, with a second START pulse during BUSY -> exactly one run, DONE=1.
- MAS_RST asserted at cycle 100 mid-run -> all outputs 0 immediately. After release, no activity until a new START edge.
